uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- Standalone UART receiver: 8N1, LSB first, 16x oversampling, majority-vote bit decisions.
- Holds each received byte until the consumer reads it; reports framing and overrun errors.
- Receive counterpart to the existing UART transmit path. Sits between the external rx pin and CPU/peripheral logic.
- Replaces the free-running single-sample receive logic.

Parameters:
- CLOCK_RATE, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bits per second.
- OVERSAMPLE, 16: samples per bit. Fixed at 16; other values are unsupported.
- TICK_DIV, CLOCK_RATE/(BAUD_RATE*OVERSAMPLE): clocks per sample tick, 27 at the defaults. Must be >= 2; elaboration fails otherwise.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- rx  in  1  asynchronous serial input; idles high.
- rx_read  in  1  consumer acknowledge; 1-cycle pulse clears rx_ready.
- err_clear  in  1  clears the sticky error flags.
- rx_data  out  8  last good byte; holds until the next good byte.
- rx_ready  out  1  level; a byte is available.
- frame_error  out  1  sticky; bad stop bit or break seen.
- overrun  out  1  sticky; a new byte arrived while rx_ready was 1 and unread.

Behaviour:
- Reset (reset==0 at a clock edge): rx_data=0x00, rx_ready=0, frame_error=0, overrun=0, state=IDLE, tick and sample counters=0, both synchronizer flops=1.
- Synchronizer: 2-flop on rx, giving rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for one cycle when the count equals TICK_DIV-1.
  - Free-running in every state.
- Sample counter: 4 bits, advances on tick, wraps 15 -> 0. Bit value = majority of rx_s taken at samples 7, 8 and 9.
- IDLE:
  - On a tick with rx_s==0: go to START, that tick counts as sample 0.
  - Otherwise stay.
- START:
  - At sample 15, majority==1: false start; go to IDLE with no output and no error.
  - At sample 15, majority==0: go to DATA, bit index=0.
- DATA:
  - At each sample 15, shift the majority bit into the shift register MSB; the register shifts right, so the byte is assembled LSB first.
  - After bit index 7, go to STOP.
- STOP: decision made at sample 9, mid-bit, so a back-to-back start edge is not missed.
  - Majority==1: commit the byte and go to IDLE.
  - Majority==0: set frame_error, discard the byte, go to BREAK.
- BREAK: stay until rx_s==1 on a tick, then go to IDLE. A held-low line produces exactly one frame_error and no bytes.
- Commit happens on the cycle after the sample-9 tick:
  - rx_data <= byte; rx_ready <= 1.
  - If rx_ready was already 1 and rx_read==0 that cycle: overrun <= 1; the new byte overwrites rx_data.
  - If rx_read==1 in the same cycle as the commit: rx_ready stays 1, no overrun.
- rx_read while rx_ready==1 and no commit: rx_ready=0 on the next cycle. rx_read while rx_ready==0 is ignored.
- err_clear clears both flags next cycle. A simultaneous error set wins over the clear.
- Latency, from the first low rx sample to rx_ready rising: 2 sync cycles + up to TICK_DIV cycles of tick alignment + (9*16+10) ticks.
- Reset mid-frame: abandon the frame, apply reset values, no partial byte.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - START_BIT=1'b0 and STOP_BIT=1'b1;
  - OVERSAMPLE=16 and the MID_SAMPLES constants 7/8/9;
  - a TICK_DIV helper function.
- Sub-module uart_baud_tick: parameterised tick generator with clock, reset and tick out, reusable by the transmit side.
- Tick counter width: $clog2(TICK_DIV).

Test Plan:
1. Send 0xA5 at 115200 with clean timing -> rx_ready=1, rx_data=0xA5, frame_error=0, overrun=0. Pulse rx_read -> rx_ready=0 next cycle.
2. Drive an rx low glitch of 81 cycles (3 ticks) -> no rx_ready, no frame_error, state back in IDLE. Then send 0x5A -> rx_data=0x5A.
3. Send 0x3C with stop bit=0 -> frame_error=1, rx_ready stays 0. Then hold rx low for 20 bit times -> still one error event, no byte. Release, send 0x55 -> rx_data=0x55. Pulse err_clear -> frame_error=0.
4. Send 0x11 then 0x22 back-to-back, no read -> overrun=1, rx_data=0x22, rx_ready=1.
5. Send 0x11, then pulse rx_read in exactly the commit cycle of 0x22 -> rx_ready=1, rx_data=0x22, overrun=0.
6. Assert reset=0 mid-DATA of 0xFF -> next cycle all outputs 0. Release, send 0x81 -> rx_data=0x81 with no spurious byte beforehand.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receive path.
package uart_pkg;

    // Receiver frame states; exported on the debug port of the receiver.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int OVERSAMPLE = 16;

    // Samples around the bit centre used for the majority vote.
    localparam logic [3:0] MID_SAMPLE_EARLY  = 4'd7;
    localparam logic [3:0] MID_SAMPLE_CENTRE = 4'd8;
    localparam logic [3:0] MID_SAMPLE_LATE   = 4'd9;

    // Last sample of a bit period; bit decisions are taken here.
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    // Clocks per oversample tick.
    function automatic int calc_tick_div(input int clock_rate, input int baud_rate,
                                         input int oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

    // Two-out-of-three vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every TICK_DIV clocks.
module uart_baud_tick #(
    parameter int TICK_DIV = 27
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("uart_baud_tick: TICK_DIV must be at least 2");
    end

    logic [CW-1:0] count;

    // Count 0..TICK_DIV-1 and wrap; never paused by the receiver state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST_COUNT);

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Holds the last good byte until read; sticky framing and overrun flags.
module uart_rx_oversampled #(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = uart_pkg::calc_tick_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_read,
    input  logic                 err_clear,
    output logic [7:0]           rx_data,
    output logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output uart_pkg::uart_state_e state
);

    import uart_pkg::*;

    if (OVERSAMPLE != 16) begin : g_bad_oversample
        $error("uart_rx_oversampled: only OVERSAMPLE=16 is supported");
    end

    logic        rx_meta;
    logic        rx_s;
    logic        tick;
    uart_state_e state_q;
    uart_state_e state_d;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        vote_early;
    logic        vote_centre;
    logic        vote_late;
    logic        majority;
    logic        shift_en;
    logic        commit_set;
    logic        frame_set;
    logic        commit_q;
    logic        frame_q;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_baud_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // At sample 9 the late vote is still on the line, so use rx_s live there
    // (the stop-bit decision happens at that tick); elsewhere use the stored vote.
    assign majority = majority3(vote_early, vote_centre,
                                (sample_cnt == MID_SAMPLE_LATE) ? rx_s : vote_late);

    // Frame state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-tick strobes.
    always_comb begin
        state_d    = state_q;
        shift_en   = 1'b0;
        commit_set = 1'b0;
        frame_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && rx_s == START_BIT) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && sample_cnt == LAST_SAMPLE) begin
                    state_d = (majority == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (tick && sample_cnt == LAST_SAMPLE) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Decide mid-bit so a start edge right after the stop bit is caught.
                if (tick && sample_cnt == MID_SAMPLE_LATE) begin
                    if (majority == STOP_BIT) begin
                        commit_set = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (tick && rx_s == STOP_BIT) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample counter, mid-bit votes, bit index and shift register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sample_cnt  <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            vote_early  <= 1'b1;
            vote_centre <= 1'b1;
            vote_late   <= 1'b1;
        end else begin
            if (tick) begin
                if (state_d == IDLE || state_d == BREAK) begin
                    sample_cnt <= '0;
                end else if (state_q == IDLE) begin
                    // The detecting tick is sample 0 of the start bit.
                    sample_cnt <= 4'd1;
                end else begin
                    sample_cnt <= sample_cnt + 4'd1;
                end
                if (sample_cnt == MID_SAMPLE_EARLY) begin
                    vote_early <= rx_s;
                end
                if (sample_cnt == MID_SAMPLE_CENTRE) begin
                    vote_centre <= rx_s;
                end
                if (sample_cnt == MID_SAMPLE_LATE) begin
                    vote_late <= rx_s;
                end
            end
            if (state_q == START && state_d == DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {majority, shift_reg[7:1]};
            end
        end
    end

    // Commit and error flags, one cycle after the stop-bit decision.
    always_ff @(posedge clock) begin
        if (!reset) begin
            commit_q    <= 1'b0;
            frame_q     <= 1'b0;
            rx_data     <= '0;
            rx_ready    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            commit_q <= commit_set;
            frame_q  <= frame_set;
            if (commit_q) begin
                rx_data  <= shift_reg;
                rx_ready <= 1'b1;
            end else if (rx_read) begin
                rx_ready <= 1'b0;
            end
            // Setting an error takes priority over a simultaneous clear.
            overrun     <= (commit_q && rx_ready && !rx_read) || (overrun && !err_clear);
            frame_error <= frame_q || (frame_error && !err_clear);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed scenarios plus random frames,
// checked against a frame-level model of the receiver outputs.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
    import uart_pkg::*;

    localparam int BAUD       = 115200;
    localparam int TICKS      = 4;
    localparam int CLK_RATE   = BAUD * 16 * TICKS;
    localparam int BIT_CLKS   = 16 * TICKS;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic        clock;
    logic        reset;
    logic        rx;
    logic        rx_read;
    logic        err_clear;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        frame_error;
    logic        overrun;
    uart_state_e state;

    int n_checks;
    int n_failures;
    int cyc;

    // Model: bytes committed and not yet consumed, plus the visible flags.
    logic [7:0] exp_q[$];
    logic [7:0] m_data;
    logic       m_overrun;
    logic       m_frame_error;

    int   t5_start;
    int   t5_rise;
    bit   t5_seen;
    logic [7:0] r_byte;
    bit         r_good;

    uart_rx_oversampled #(
        .CLOCK_RATE(CLK_RATE),
        .BAUD_RATE (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .rx_read    (rx_read),
        .err_clear  (err_clear),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .frame_error(frame_error),
        .overrun    (overrun),
        .state      (state)
    );

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Watchdog.
    initial begin
        #3_000_000;
        n_failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (good) begin
            if (exp_q.size() != 0) m_overrun = 1'b1;
            exp_q.push_back(b);
            m_data = b;
        end else begin
            m_frame_error = 1'b1;
        end
    endtask

    task automatic model_read();
        exp_q.delete();
    endtask

    task automatic model_clear();
        m_overrun     = 1'b0;
        m_frame_error = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_data        = 8'h00;
        m_overrun     = 1'b0;
        m_frame_error = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ready"}, rx_ready, (exp_q.size() != 0));
        check({tag, "_data"}, rx_data, m_data);
        check({tag, "_overrun"}, overrun, m_overrun);
        check({tag, "_frame_error"}, frame_error, m_frame_error);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        @(negedge clock);
        rx_read = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_failures = 0;
        cyc        = 0;
        rx         = 1'b1;
        rx_read    = 1'b0;
        err_clear  = 1'b0;
        reset      = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_data", rx_data, 8'h00);
        check("rst_ready", rx_ready, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_state", state, IDLE);
        reset = 1'b1;
        idle(BIT_CLKS);

        // 1: clean byte, then read
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1);
        check_all("t1");
        pulse_read();
        model_read();
        check("t1_read_clears", rx_ready, 1'b0);

        // 2: short low glitch is a false start
        idle(BIT_CLKS);
        rx = 1'b0;
        repeat (3 * TICKS) @(negedge clock);
        idle(20 * TICKS);
        check("t2_glitch_state", state, IDLE);
        check_all("t2_glitch");
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1);
        check_all("t2");
        pulse_read();
        model_read();

        // 3: bad stop bit, then held-low line, then recovery
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 0);
        check_all("t3_bad_stop");
        rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clock);
        check_all("t3_held_low");
        pulse_clear();
        model_clear();
        rx = 1'b0;
        repeat (4 * BIT_CLKS) @(negedge clock);
        check("t3_break_state", state, BREAK);
        check_all("t3_single_event");
        idle(2 * BIT_CLKS);
        check("t3_release_state", state, IDLE);
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1);
        check_all("t3");
        pulse_read();
        model_read();

        // 4: back-to-back bytes without a read
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h11, 1);
        model_frame(8'h22, 1);
        check_all("t4");

        // 5: read coinciding with the commit of the second byte
        pulse_read();
        model_read();
        pulse_clear();
        model_clear();
        idle(BIT_CLKS);
        check("t5_pre_ready", rx_ready, 1'b0);
        t5_start = cyc;
        t5_seen  = 0;
        t5_rise  = 0;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                for (int i = 0; i < 2 * FRAME_CLKS && !t5_seen; i++) begin
                    @(negedge clock);
                    if (rx_ready) begin
                        t5_seen = 1;
                        t5_rise = cyc;
                    end
                end
                check("t5_first_commit_seen", t5_seen, 1);
                if (t5_seen) begin
                    // Same tick phase for the second frame, one frame later.
                    while (cyc < t5_rise + FRAME_CLKS - 1) @(negedge clock);
                    rx_read = 1'b1;
                    @(negedge clock);
                    rx_read = 1'b0;
                end
            end
        join
        model_frame(8'h11, 1);
        model_read();
        model_frame(8'h22, 1);
        check_all("t5");
        check("t5_latency_window", (t5_rise - t5_start) < FRAME_CLKS, 1);

        // 6: reset in the middle of a frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        check("t6_mid_data_state", state, DATA);
        reset = 1'b0;
        @(negedge clock);
        model_reset();
        check_all("t6_reset");
        check("t6_reset_state", state, IDLE);
        reset = 1'b1;
        idle(6 * BIT_CLKS);
        check_all("t6_no_spurious");
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1);
        check_all("t6");
        pulse_read();
        model_read();
        idle(BIT_CLKS);

        // Random frames with random gaps, reads and clears
        for (int n = 0; n < 20; n++) begin
            idle($urandom_range(0, 40));
            r_byte = 8'($urandom_range(0, 255));
            r_good = ($urandom_range(0, 7) != 0);
            send_frame(r_byte, r_good ? 1'b1 : 1'b0);
            model_frame(r_byte, r_good);
            if (!r_good) idle(2 * BIT_CLKS);
            check_all("rnd");
            if ($urandom_range(0, 1) == 1) begin
                pulse_read();
                model_read();
                check("rnd_read", rx_ready, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                model_clear();
                check_all("rnd_clear");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
